// File: rtl/fsm_progress_watchdog.sv
// fsm_progress_watchdog
// Watches the 2-bit state of the idle/active1/active2 control FSM. It checks
// that active1 reaches active2 within TIMEOUT samples, measures the active1
// dwell, and flags illegal states and transitions. Statistics are sticky or
// saturating so they can be read back at any time.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   enable         monitor enable; low parks the monitor in M_IDLE
//   clear          synchronous clear of statistics and sticky flag
//   state_in       watched FSM state (00 idle, 01 active1, 10 active2, 11 other)
//   latency_valid  one-cycle pulse when latency is updated by a passing episode
//   latency        active1 dwell of the last passing episode, in samples
//   max_latency    largest latency since reset/clear
//   timeout_pulse  one-cycle pulse when active1 overstays TIMEOUT samples
//   timeout_sticky set by a timeout, held until clear/reset
//   illegal_pulse  one-cycle pulse on an illegal state or transition
//   pass_count     passing episodes, saturating
//   fail_count     timeouts, saturating
//   illegal_count  illegal events, saturating
module fsm_progress_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [1:0]       state_in,
  output logic             latency_valid,
  output logic [CNT_W-1:0] latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             timeout_pulse,
  output logic             timeout_sticky,
  output logic             illegal_pulse,
  output logic [EVT_W-1:0] pass_count,
  output logic [EVT_W-1:0] fail_count,
  output logic [EVT_W-1:0] illegal_count
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_A1    = 2'b01;
  localparam logic [1:0] ST_A2    = 2'b10;
  localparam logic [1:0] ST_OTHER = 2'b11;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_ONE   = {{(EVT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_MAX   = {EVT_W{1'b1}};

  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE, M_FAIL} monState_e;

  monState_e        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [1:0]       prevQ, prevD;
  logic             validQ, validD;
  logic [CNT_W-1:0] latencyQ, latencyD;
  logic [CNT_W-1:0] maxQ, maxD;
  logic             timeoutQ, timeoutD;
  logic             stickyQ, stickyD;
  logic             illegalQ, illegalD;
  logic [EVT_W-1:0] passQ, passD;
  logic [EVT_W-1:0] failQ, failD;
  logic [EVT_W-1:0] illCntQ, illCntD;
  logic             passInc, failInc, illegalEvt;

  // Only these transitions of the watched FSM are legal; 11 may only exit to 00.
  function automatic logic legalTrans(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      {ST_IDLE, ST_IDLE}, {ST_IDLE, ST_A1}, {ST_A1, ST_A1},
      {ST_A1, ST_A2}, {ST_A2, ST_A2}, {ST_OTHER, ST_IDLE}: legalTrans = 1'b1;
      default: legalTrans = 1'b0;
    endcase
  endfunction

  // Next-state logic: monitor FSM, illegal detection, then statistics.
  // prev always follows state_in so the first enabled cycle sees the true
  // previous sample even after a disabled stretch.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    prevD      = state_in;
    validD     = 1'b0;
    latencyD   = latencyQ;
    maxD       = maxQ;
    timeoutD   = 1'b0;
    stickyD    = stickyQ;
    illegalD   = 1'b0;
    passD      = passQ;
    failD      = failQ;
    illCntD    = illCntQ;
    passInc    = 1'b0;
    failInc    = 1'b0;
    illegalEvt = 1'b0;

    if (!enable) begin
      stateD = M_IDLE;
      cntD   = '0;
    end else begin
      illegalEvt = (state_in == ST_OTHER) || !legalTrans(prevQ, state_in);
      case (stateQ)
        M_IDLE: begin
          if (state_in == ST_A1) begin
            stateD = M_WAIT;
            cntD   = CNT_ONE;
          end
        end
        M_WAIT: begin
          case (state_in)
            ST_A2: begin
              latencyD = cntQ;
              validD   = 1'b1;
              passInc  = 1'b1;
              if (cntQ > maxQ) maxD = cntQ;
              stateD   = M_DONE;
            end
            ST_A1: begin
              // cnt already holds TIMEOUT samples, so this is sample TIMEOUT+1.
              if (cntQ < TIMEOUT_C) begin
                cntD = cntQ + CNT_ONE;
              end else begin
                timeoutD = 1'b1;
                stickyD  = 1'b1;
                failInc  = 1'b1;
                stateD   = M_FAIL;
              end
            end
            default: stateD = M_IDLE;
          endcase
        end
        M_DONE: begin
          case (state_in)
            ST_A2: stateD = M_DONE;
            ST_A1: begin
              stateD = M_WAIT;
              cntD   = CNT_ONE;
            end
            default: stateD = M_IDLE;
          endcase
        end
        M_FAIL: begin
          // A late active2 closes the episode without counting it as a pass.
          case (state_in)
            ST_A1:   stateD = M_FAIL;
            ST_A2:   stateD = M_DONE;
            default: stateD = M_IDLE;
          endcase
        end
        default: stateD = M_IDLE;
      endcase
    end

    illegalD = illegalEvt;
    if (passInc && (passQ != EVT_MAX))      passD   = passQ + EVT_ONE;
    if (failInc && (failQ != EVT_MAX))      failD   = failQ + EVT_ONE;
    if (illegalEvt && (illCntQ != EVT_MAX)) illCntD = illCntQ + EVT_ONE;

    // clear wins over any same-cycle update but leaves pulses and the monitor alone.
    if (clear) begin
      latencyD = '0;
      maxD     = '0;
      stickyD  = 1'b0;
      passD    = '0;
      failD    = '0;
      illCntD  = '0;
    end
  end

  // All state and outputs registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= M_IDLE;
      cntQ     <= '0;
      prevQ    <= ST_IDLE;
      validQ   <= 1'b0;
      latencyQ <= '0;
      maxQ     <= '0;
      timeoutQ <= 1'b0;
      stickyQ  <= 1'b0;
      illegalQ <= 1'b0;
      passQ    <= '0;
      failQ    <= '0;
      illCntQ  <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      prevQ    <= prevD;
      validQ   <= validD;
      latencyQ <= latencyD;
      maxQ     <= maxD;
      timeoutQ <= timeoutD;
      stickyQ  <= stickyD;
      illegalQ <= illegalD;
      passQ    <= passD;
      failQ    <= failD;
      illCntQ  <= illCntD;
    end
  end

  assign latency_valid  = validQ;
  assign latency        = latencyQ;
  assign max_latency    = maxQ;
  assign timeout_pulse  = timeoutQ;
  assign timeout_sticky = stickyQ;
  assign illegal_pulse  = illegalQ;
  assign pass_count     = passQ;
  assign fail_count     = failQ;
  assign illegal_count  = illCntQ;

endmodule

// File: tb/tb_fsm_progress_watchdog.sv
// tb_fsm_progress_watchdog
// Directed bench for fsm_progress_watchdog. A default-parameter instance is
// checked throughout; a second instance with 2-bit event counters shares the
// same stimulus and is checked where saturation matters.
module tb_fsm_progress_watchdog;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [1:0] state_in;

  logic       latencyValid, timeoutPulse, timeoutSticky, illegalPulse;
  logic [7:0] latency, maxLatency, passCount, failCount, illegalCount;

  logic       satValid, satTimeout, satSticky, satIllegal;
  logic [7:0] satLatency, satMax;
  logic [1:0] satPass, satFail, satIllCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       doRst;
    logic       en;
    logic       clr;
    logic [1:0] st;
    logic       expValid;
    logic [7:0] expLat;
    logic [7:0] expMax;
    logic       expTo;
    logic       expStk;
    logic       expIl;
    logic [7:0] expPass;
    logic [7:0] expFail;
    logic [7:0] expIllCnt;
  } vec_t;

  vec_t vecQ[$];

  fsm_progress_watchdog #(.TIMEOUT(16), .CNT_W(8), .EVT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state_in(state_in),
    .latency_valid(latencyValid), .latency(latency), .max_latency(maxLatency),
    .timeout_pulse(timeoutPulse), .timeout_sticky(timeoutSticky),
    .illegal_pulse(illegalPulse), .pass_count(passCount), .fail_count(failCount),
    .illegal_count(illegalCount)
  );

  fsm_progress_watchdog #(.TIMEOUT(16), .CNT_W(8), .EVT_W(2)) dutSat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state_in(state_in),
    .latency_valid(satValid), .latency(satLatency), .max_latency(satMax),
    .timeout_pulse(satTimeout), .timeout_sticky(satSticky),
    .illegal_pulse(satIllegal), .pass_count(satPass), .fail_count(satFail),
    .illegal_count(satIllCnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [7:0] lat,
                             input logic [7:0] mx, input logic to, input logic stk,
                             input logic il, input logic [7:0] pc, input logic [7:0] fc,
                             input logic [7:0] ic);
    checkVal({tag, ".latency_valid"}, 32'(latencyValid), 32'(v));
    checkVal({tag, ".latency"}, 32'(latency), 32'(lat));
    checkVal({tag, ".max_latency"}, 32'(maxLatency), 32'(mx));
    checkVal({tag, ".timeout_pulse"}, 32'(timeoutPulse), 32'(to));
    checkVal({tag, ".timeout_sticky"}, 32'(timeoutSticky), 32'(stk));
    checkVal({tag, ".illegal_pulse"}, 32'(illegalPulse), 32'(il));
    checkVal({tag, ".pass_count"}, 32'(passCount), 32'(pc));
    checkVal({tag, ".fail_count"}, 32'(failCount), 32'(fc));
    checkVal({tag, ".illegal_count"}, 32'(illegalCount), 32'(ic));
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic applyStimulus(input logic en, input logic clr, input logic [1:0] st);
    enable   = en;
    clear    = clr;
    state_in = st;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    enable   = 1'b1;
    clear    = 1'b0;
    state_in = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic addVec(input logic r, input logic en, input logic clr, input logic [1:0] st,
                        input logic v, input logic [7:0] lat, input logic [7:0] mx,
                        input logic to, input logic stk, input logic il,
                        input logic [7:0] pc, input logic [7:0] fc, input logic [7:0] ic);
    vec_t t;
    t.doRst = r; t.en = en; t.clr = clr; t.st = st;
    t.expValid = v; t.expLat = lat; t.expMax = mx; t.expTo = to; t.expStk = stk;
    t.expIl = il; t.expPass = pc; t.expFail = fc; t.expIllCnt = ic;
    vecQ.push_back(t);
  endtask

  initial begin
    // Nominal episode 00,00,01,10,10: one pass with latency 1.
    addVec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    addVec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    addVec(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    addVec(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0);
    addVec(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0);
    // Illegal sequence after reset: 00->10, 10->01, 01->00, 11, then legal 11->00.
    addVec(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd1);
    addVec(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd2);
    addVec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd3);
    addVec(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd4);
    addVec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4);
    // clear zeroes the illegal count; disabled 11 gives no pulse; 11->00 is legal.
    addVec(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    addVec(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    addVec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Reset state.
    reset    = 1'b1;
    enable   = 1'b0;
    clear    = 1'b0;
    state_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    reset = 1'b0;

    foreach (vecQ[i]) begin
      if (vecQ[i].doRst) doReset();
      applyStimulus(vecQ[i].en, vecQ[i].clr, vecQ[i].st);
      checkOutput($sformatf("vec%0d", i), vecQ[i].expValid, vecQ[i].expLat, vecQ[i].expMax,
                  vecQ[i].expTo, vecQ[i].expStk, vecQ[i].expIl, vecQ[i].expPass,
                  vecQ[i].expFail, vecQ[i].expIllCnt);
    end

    // Longest legal dwell: 16 active1 samples then active2.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b01);
      checkVal($sformatf("dwell16.a1_%0d.timeout", i), 32'(timeoutPulse), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 2'b10);
    checkOutput("dwell16.pass", 1'b1, 8'd16, 8'd16, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0);

    // Timeout on the 17th sample, no repeat pulse, late arrival not counted, then clear.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b01);
      checkVal($sformatf("to.a1_%0d.timeout", i), 32'(timeoutPulse), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 2'b01);
    checkOutput("to.17th", 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 2'b01);
    checkOutput("to.hold", 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 2'b10);
    checkOutput("to.late", 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 8'd0);
    applyStimulus(1'b1, 1'b1, 2'b10);
    checkOutput("to.clear", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Saturation: five passes (episodes 2..5 each start with an illegal 10->01).
    doReset();
    for (int e = 0; e < 5; e++) begin
      applyStimulus(1'b1, 1'b0, 2'b01);
      applyStimulus(1'b1, 1'b0, 2'b10);
    end
    checkVal("sat.pass8", 32'(passCount), 32'd5);
    checkVal("sat.pass2", 32'(satPass), 32'd3);
    checkVal("sat.ill8", 32'(illegalCount), 32'd4);
    checkVal("sat.ill2", 32'(satIllCnt), 32'd3);
    checkVal("sat.max", 32'(maxLatency), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b01);
    checkVal("sat.ill2_hold", 32'(satIllCnt), 32'd3);
    // Sixth pass lands in the same cycle as clear.
    applyStimulus(1'b1, 1'b1, 2'b10);
    checkVal("clr.valid", 32'(latencyValid), 32'd1);
    checkVal("clr.pass8", 32'(passCount), 32'd0);
    checkVal("clr.pass2", 32'(satPass), 32'd0);
    checkVal("clr.max", 32'(maxLatency), 32'd0);
    checkVal("clr.latency", 32'(latency), 32'd0);
    checkVal("clr.ill8", 32'(illegalCount), 32'd0);

    // Asynchronous reset between edges in the middle of a dwell (cnt=5).
    doReset();
    applyStimulus(1'b1, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 2'b01);
    checkVal("arst.pre_pass", 32'(passCount), 32'd1);
    checkVal("arst.pre_ill", 32'(illegalCount), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst.now", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b0, 2'b10);
    checkOutput("arst.after", 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0);

    // Disabled 30-sample dwell: no timeout, then a fresh count once enabled.
    doReset();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b01);
      checkVal($sformatf("dis.%0d.timeout", i), 32'(timeoutPulse), 32'd0);
      checkVal($sformatf("dis.%0d.illegal", i), 32'(illegalPulse), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b01);
      checkVal($sformatf("ena.%0d.timeout", i), 32'(timeoutPulse), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 2'b10);
    checkOutput("ena.pass", 1'b1, 8'd16, 8'd16, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
